// File: rtl/gcd_pkg.sv
// -----------------------------------------------------------------------------
// gcd_pkg
// Purpose : Shared types and default parameters for the subtractive GCD engine.
// Contents: gcd_state_e    - control FSM state encoding (IDLE, CALC, DONE)
//           GCD_WIDTH_DEF  - default operand/result width
//           GCD_ITER_W_DEF - default iteration counter width
// -----------------------------------------------------------------------------
package gcd_pkg;

    localparam int unsigned GCD_WIDTH_DEF  = 16;
    localparam int unsigned GCD_ITER_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } gcd_state_e;

endpackage : gcd_pkg

// File: rtl/gcd_dp_w.sv
// -----------------------------------------------------------------------------
// gcd_dp_w
// Purpose : Datapath of the GCD engine. Holds the A/B operand registers, one
//           shared subtractor (larger minus smaller), the magnitude comparator
//           and the zero detectors. Sequenced entirely by strobes from the FSM.
// Ports   : clk          - rising-edge clock
//           rst_n        - synchronous active-low reset, clears A and B
//           i_load       - capture i_a/i_b into A/B
//           i_sub_a      - A <= A - B (issued only when A > B)
//           i_sub_b      - B <= B - A (issued only when A < B)
//           i_a, i_b     - operands to capture
//           o_a          - current value of A
//           o_a_or_b     - A | B, the result when one operand is zero
//           o_a_gt_b     - A > B
//           o_a_lt_b     - A < B
//           o_eq         - A == B
//           o_any_zero   - A == 0 or B == 0
//           o_both_zero  - A == 0 and B == 0
// -----------------------------------------------------------------------------
module gcd_dp_w
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_sub_a,
    input  logic             i_sub_b,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_a_or_b,
    output logic             o_a_gt_b,
    output logic             o_a_lt_b,
    output logic             o_eq,
    output logic             o_any_zero,
    output logic             o_both_zero
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] w_minuend;
    logic [WIDTH-1:0] w_subtrahend;
    logic [WIDTH-1:0] w_diff;
    logic             w_gt;
    logic             w_a_zero;
    logic             w_b_zero;

    assign w_gt     = (r_a > r_b);
    assign w_a_zero = (r_a == {WIDTH{1'b0}});
    assign w_b_zero = (r_b == {WIDTH{1'b0}});

    // One subtractor serves both directions: the larger operand is always the
    // minuend, so the difference never borrows.
    assign w_minuend    = w_gt ? r_a : r_b;
    assign w_subtrahend = w_gt ? r_b : r_a;
    assign w_diff       = w_minuend - w_subtrahend;

    assign o_a         = r_a;
    assign o_a_or_b    = r_a | r_b;
    assign o_a_gt_b    = w_gt;
    assign o_a_lt_b    = (r_a < r_b);
    assign o_eq        = (r_a == r_b);
    assign o_any_zero  = w_a_zero | w_b_zero;
    assign o_both_zero = w_a_zero & w_b_zero;

    // Operand registers: load, reduce the larger one, or hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a <= {WIDTH{1'b0}};
            r_b <= {WIDTH{1'b0}};
        end else if (i_load) begin
            r_a <= i_a;
            r_b <= i_b;
        end else if (i_sub_a) begin
            r_a <= w_diff;
        end else if (i_sub_b) begin
            r_b <= w_diff;
        end else begin
            r_a <= r_a;
            r_b <= r_b;
        end
    end

endmodule : gcd_dp_w

// File: rtl/gcd_engine.sv
// -----------------------------------------------------------------------------
// gcd_engine
// Purpose : Self-sequenced GCD unit using repeated subtraction. Operands are
//           accepted with a valid/ready handshake, the control FSM drives the
//           gcd_dp_w datapath, and the result is offered with a valid/ready
//           handshake together with a saturating step count and a flag for
//           the both-operands-zero case.
// Ports   : clk        - rising-edge clock
//           rst_n      - synchronous active-low reset (aborts any job)
//           in_valid   - operand pair valid
//           in_ready   - engine idle and able to accept operands (registered)
//           in_a, in_b - unsigned operands
//           out_valid  - result valid, held until accepted (registered)
//           out_ready  - consumer accepts the result
//           out_gcd    - gcd(A,B)
//           out_iters  - number of subtraction steps, saturating
//           out_zero   - both operands were zero
// -----------------------------------------------------------------------------
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH  = GCD_WIDTH_DEF,
    parameter int ITER_W = GCD_ITER_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_gcd,
    output logic [ITER_W-1:0] out_iters,
    output logic              out_zero
);

    localparam logic [ITER_W-1:0] ITER_MAX = {ITER_W{1'b1}};
    localparam logic [ITER_W-1:0] ITER_ONE = ITER_W'(1);

    gcd_state_e        r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_gcd;
    logic [ITER_W-1:0] r_cnt;
    logic [ITER_W-1:0] r_out_iters;
    logic              r_zero;

    logic              w_load;
    logic              w_sub_a;
    logic              w_sub_b;
    logic [WIDTH-1:0]  w_a;
    logic [WIDTH-1:0]  w_a_or_b;
    logic              w_gt;
    logic              w_lt;
    logic              w_eq;
    logic              w_any_zero;
    logic              w_both_zero;

    gcd_dp_w #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_sub_a     (w_sub_a),
        .i_sub_b     (w_sub_b),
        .i_a         (in_a),
        .i_b         (in_b),
        .o_a         (w_a),
        .o_a_or_b    (w_a_or_b),
        .o_a_gt_b    (w_gt),
        .o_a_lt_b    (w_lt),
        .o_eq        (w_eq),
        .o_any_zero  (w_any_zero),
        .o_both_zero (w_both_zero)
    );

    // Datapath strobes decoded from the current state and operand compare.
    always_comb begin
        w_load  = 1'b0;
        w_sub_a = 1'b0;
        w_sub_b = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load = in_valid;
            end
            ST_CALC: begin
                if (!w_any_zero && !w_eq) begin
                    w_sub_a = w_gt;
                    w_sub_b = w_lt;
                end else begin
                    w_sub_a = 1'b0;
                    w_sub_b = 1'b0;
                end
            end
            default: begin
                w_load  = 1'b0;
                w_sub_a = 1'b0;
                w_sub_b = 1'b0;
            end
        endcase
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_gcd       <= {WIDTH{1'b0}};
            r_cnt       <= {ITER_W{1'b0}};
            r_out_iters <= {ITER_W{1'b0}};
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_state    <= ST_CALC;
                        r_in_ready <= 1'b0;
                        r_cnt      <= {ITER_W{1'b0}};
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (w_any_zero) begin
                        r_gcd       <= w_a_or_b;
                        r_zero      <= w_both_zero;
                        r_out_iters <= r_cnt;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else if (w_eq) begin
                        r_gcd       <= w_a;
                        r_zero      <= 1'b0;
                        r_out_iters <= r_cnt;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else if (r_cnt != ITER_MAX) begin
                        // A subtraction is issued this cycle; count it.
                        r_cnt <= r_cnt + ITER_ONE;
                    end else begin
                        // Saturated: keep subtracting but stop counting.
                        r_cnt <= r_cnt;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_gcd   = r_gcd;
    assign out_iters = r_out_iters;
    assign out_zero  = r_zero;

endmodule : gcd_engine

// File: tb/tb_gcd_engine.sv
// -----------------------------------------------------------------------------
// tb_gcd_engine
// Two engines (ITER_W=16 and ITER_W=8) share one stimulus stream. A queue-based
// reference model computes each job's gcd, step count and completion cycle
// with the Euclidean algorithm (steps = sum of quotients - 1), and a compare
// process checks handshake and result outputs of both engines every cycle.
// -----------------------------------------------------------------------------
module tb_gcd_engine;

    localparam int W = 16;

    typedef struct {
        longint g;
        longint steps;
        bit     z;
        longint done;
    } job_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          out_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;

    logic          in_ready16, out_valid16, out_zero16;
    logic [W-1:0]  out_gcd16;
    logic [15:0]   out_iters16;
    logic          in_ready8, out_valid8, out_zero8;
    logic [W-1:0]  out_gcd8;
    logic [7:0]    out_iters8;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc   = 0;
    bit     rst_seen = 1'b0;
    job_t   q[$];

    always #5 clk = ~clk;

    gcd_engine #(.WIDTH(W), .ITER_W(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid16), .out_ready(out_ready),
        .out_gcd(out_gcd16), .out_iters(out_iters16), .out_zero(out_zero16)
    );

    gcd_engine #(.WIDTH(W), .ITER_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid8), .out_ready(out_ready),
        .out_gcd(out_gcd8), .out_iters(out_iters8), .out_zero(out_zero8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    // Euclid: subtractive step count equals sum of division quotients minus one.
    function automatic void ref_gcd(input longint a, input longint b,
                                    output longint g, output longint steps);
        longint x, y, t, s;
        if (a == 0 || b == 0) begin
            g     = a | b;
            steps = 0;
        end else begin
            x = a; y = b; s = 0;
            while (y != 0) begin
                s += x / y;
                t = x % y;
                x = y;
                y = t;
            end
            g     = x;
            steps = s - 1;
        end
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint m;
        m = (longint'(1) << w) - 1;
        return (v > m) ? m : v;
    endfunction

    // Reference model: advances on each rising edge using pre-edge inputs.
    initial begin
        job_t   j;
        longint g, s;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                q.delete();
                rst_seen = 1'b1;
            end else begin
                rst_seen = 1'b0;
                if (q.size() != 0) begin
                    if ((cyc - 1) >= q[0].done && out_ready)
                        void'(q.pop_front());
                end else if (in_valid) begin
                    ref_gcd(longint'(in_a), longint'(in_b), g, s);
                    j.g     = g;
                    j.steps = s;
                    j.z     = (in_a == 16'd0) && (in_b == 16'd0);
                    j.done  = cyc + s + 1;
                    q.push_back(j);
                end
            end
        end
    end

    // Compare process: checks both engines on every falling edge.
    initial begin
        bit busy, exp_v;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                busy  = (q.size() != 0);
                exp_v = busy && (cyc >= q[0].done);
                chk("in_ready16", 64'(in_ready16), 64'(!busy));
                chk("in_ready8", 64'(in_ready8), 64'(!busy));
                chk("out_valid16", 64'(out_valid16), 64'(exp_v));
                chk("out_valid8", 64'(out_valid8), 64'(exp_v));
                if (exp_v) begin
                    chk("gcd16", 64'(out_gcd16), 64'(q[0].g));
                    chk("iters16", 64'(out_iters16), 64'(sat(q[0].steps, 16)));
                    chk("zero16", 64'(out_zero16), 64'(q[0].z));
                    chk("gcd8", 64'(out_gcd8), 64'(q[0].g));
                    chk("iters8", 64'(out_iters8), 64'(sat(q[0].steps, 8)));
                    chk("zero8", 64'(out_zero8), 64'(q[0].z));
                end
                if (rst_seen) begin
                    chk("rst_gcd16", 64'(out_gcd16), 64'd0);
                    chk("rst_iters16", 64'(out_iters16), 64'd0);
                    chk("rst_zero16", 64'(out_zero16), 64'd0);
                    chk("rst_gcd8", 64'(out_gcd8), 64'd0);
                    chk("rst_iters8", 64'(out_iters8), 64'd0);
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            if (in_ready16) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout(name);
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b);
        wait_idle("drive_idle");
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
    endtask

    // Counts rising edges from the accepting edge until out_valid is seen.
    task automatic wait_valid(output int lat);
        bit ok;
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid16) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("wait_valid");
    endtask

    initial begin
        longint g, s;
        int     lat;
        logic [W-1:0] ra, rb;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = 16'd0; in_b = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Pin the reference model with hand-computed values.
        ref_gcd(64'd48, 64'd18, g, s);
        chk("pin_48_18_g", 64'(g), 64'd6);
        chk("pin_48_18_s", 64'(s), 64'd4);
        ref_gcd(64'd21, 64'd14, g, s);
        chk("pin_21_14_s", 64'(s), 64'd2);
        ref_gcd(64'd65535, 64'd1, g, s);
        chk("pin_worst_s", 64'(s), 64'd65534);
        chk("pin_sat8", 64'(sat(s, 8)), 64'd255);
        ref_gcd(64'd17, 64'd5, g, s);
        chk("pin_17_5_s", 64'(s), 64'd6);

        // Basic subtraction case.
        drive(16'd48, 16'd18);
        wait_valid(lat);
        chk("lat_48_18", 64'(lat), 64'd5);
        chk("gcd_48_18", 64'(out_gcd16), 64'd6);
        chk("iters_48_18", 64'(out_iters16), 64'd4);
        chk("zero_48_18", 64'(out_zero16), 64'd0);

        // Equal and zero operands.
        drive(16'd12, 16'd12);
        wait_valid(lat);
        chk("lat_12_12", 64'(lat), 64'd1);
        chk("gcd_12_12", 64'(out_gcd16), 64'd12);
        drive(16'd0, 16'd9);
        wait_valid(lat);
        chk("lat_0_9", 64'(lat), 64'd1);
        chk("gcd_0_9", 64'(out_gcd16), 64'd9);
        chk("zero_0_9", 64'(out_zero16), 64'd0);
        drive(16'd0, 16'd0);
        wait_valid(lat);
        chk("gcd_0_0", 64'(out_gcd16), 64'd0);
        chk("zero_0_0", 64'(out_zero16), 64'd1);

        // Backpressure with in_valid toggling during the stall.
        wait_idle("bp_idle");
        out_ready = 1'b0;
        drive(16'd21, 16'd14);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            in_a     = 16'($urandom);
            in_b     = 16'($urandom);
        end
        in_valid = 1'b0;
        chk("bp_valid", 64'(out_valid16), 64'd1);
        chk("bp_gcd", 64'(out_gcd16), 64'd7);
        chk("bp_iters", 64'(out_iters16), 64'd2);
        out_ready = 1'b1;

        // Worst case and counter saturation.
        drive(16'd65535, 16'd1);
        wait_valid(lat);
        chk("worst_gcd", 64'(out_gcd16), 64'd1);
        chk("worst_iters16", 64'(out_iters16), 64'd65534);
        chk("worst_iters8", 64'(out_iters8), 64'd255);
        chk("worst_gcd8", 64'(out_gcd8), 64'd1);

        // Reset in the middle of a job.
        drive(16'd1000, 16'd3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_in_ready", 64'(in_ready16), 64'd1);
        chk("midrst_valid", 64'(out_valid16), 64'd0);
        chk("midrst_gcd", 64'(out_gcd16), 64'd0);
        drive(16'd9, 16'd6);
        wait_valid(lat);
        chk("post_rst_gcd", 64'(out_gcd16), 64'd3);
        chk("post_rst_iters", 64'(out_iters16), 64'd2);

        // Back-to-back jobs with in_valid held high.
        wait_idle("b2b_idle");
        in_a = 16'd35; in_b = 16'd10; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_a = 16'd17; in_b = 16'd5;
        wait_valid(lat);
        chk("b2b_first", 64'(out_gcd16), 64'd5);
        wait_idle("b2b_idle2");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(lat);
        chk("b2b_second", 64'(out_gcd16), 64'd1);
        chk("b2b_second_iters", 64'(out_iters16), 64'd6);

        // Randomized jobs with random output backpressure.
        for (int n = 0; n < 40; n++) begin
            ra = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(0, 255));
            rb = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(0, 255));
            drive(ra, rb);
            for (int i = 0; i < 5000; i++) begin
                @(negedge clk);
                if (in_ready16) break;
                out_ready = 1'($urandom_range(0, 1));
            end
        end
        out_ready = 1'b1;
        wait_idle("final_idle");
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_gcd_engine

// File: doc/gcd_engine.md
# gcd_engine

Parametrised, self-sequenced GCD unit that computes the greatest common divisor of two unsigned operands by repeated subtraction. It bundles the operand registers, subtractor, comparator and control FSM into one block, so the surrounding design no longer has to sequence load and select strobes by hand. Operands enter through a valid/ready input handshake. Results leave through a valid/ready output handshake, together with an iteration count and a zero-operand flag.

## Interface
- WIDTH, 16, operand and result width in bits (≥2)
- ITER_W, 16, width of the iteration counter (≥1)

- clk  input  1  rising-edge clock, the only clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  engine can accept operands; high only in IDLE
- in_a  input  WIDTH  operand A, unsigned
- in_b  input  WIDTH  operand B, unsigned
- out_valid  output  1  result valid; held until accepted
- out_ready  input  1  consumer accepts the result
- out_gcd  output  WIDTH  gcd(A,B)
- out_iters  output  ITER_W  subtraction steps taken, saturating
- out_zero  output  1  both operands were zero; out_gcd = 0

## Operation
- FSM has three states: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - When in_valid & in_ready at a clock edge: A ← in_a, B ← in_b, iteration count ← 0, go to CALC.
- CALC: each cycle, evaluate the registered A and B:
  - A==0 or B==0: result ← A|B; out_zero ← (A==0 & B==0); go to DONE. No iteration is counted.
  - A==B: result ← A; go to DONE.
  - A>B: A ← A−B; count += 1; stay in CALC.
  - A<B: B ← B−A; count += 1; stay in CALC.
- DONE:
  - out_valid = 1. out_gcd, out_iters and out_zero are stable.
  - When out_valid & out_ready: go to IDLE.
- Arithmetic: unsigned, WIDTH bits. The subtrahend is always ≤ the minuend, so no borrow occurs.
- Counter: saturates at 2^ITER_W−1 and does not wrap. The computation continues to completion after saturation.
- in_valid is ignored outside IDLE. Operands are captured only on the accepting edge. Later changes to in_a and in_b have no effect.
- Result outputs hold their last values in IDLE and CALC. They are meaningful only while out_valid = 1.

## Timing
- Reset (rst_n low at a rising edge):
  - state = IDLE; in_ready = 1 after release.
  - out_valid = 0, out_gcd = 0, out_iters = 0, out_zero = 0.
  - A and B are cleared.
- Reset asserted during CALC or DONE aborts the job. Any pending result is discarded. No out_valid pulse follows.
- Latency: out_valid rises N+1 edges after the accepting edge, where N is the number of subtraction steps.
  - Zero or equal operands: 1 edge.
- Throughput:
  - out_valid drops on the edge after the out handshake, and in_ready rises on that same edge.
  - The next operand pair can be accepted one cycle later at the earliest.
- out_ready held low stalls DONE indefinitely. All outputs stay stable during the stall.
- in_ready is a registered state decode and does not depend combinationally on in_valid. out_valid is likewise a registered state decode and does not depend on out_ready.

## Structure
- Package gcd_pkg:
  - state enum typedef (IDLE, CALC, DONE);
  - default WIDTH and ITER_W constants.
- One sub-module, gcd_dp_w:
  - parametrised datapath holding the A/B registers, shared subtractor, comparator (lt/gt/eq) and zero detect;
  - driven by load and select strobes from the FSM in gcd_engine.
- The counter and result registers live in gcd_engine.

## Test plan
- Basic subtraction case:
  - A=48, B=18, out_ready tied high → out_gcd=6, out_iters=4, out_zero=0.
  - out_valid rises 5 edges after acceptance.
- Equal and zero operands:
  - A=12, B=12 → out_gcd=12, iters=0, latency 1 edge.
  - A=0, B=9 → out_gcd=9, iters=0, out_zero=0.
  - A=0, B=0 → out_gcd=0, out_zero=1.
- Backpressure:
  - A=21, B=14, out_ready low for 10 cycles after out_valid rises → out_gcd=7 and out_iters=2 stay stable and out_valid stays high.
  - Toggling in_valid during the stall has no effect.
- Worst case and saturation:
  - WIDTH=16, A=65535, B=1 → out_gcd=1, out_iters=65534.
  - Same operands with ITER_W=8 → out_iters=255, out_gcd=1.
- Reset during a job:
  - Assert rst_n=0 mid-CALC while computing gcd(1000,3) → next cycle all outputs are 0 and in_ready=1.
  - A new job gcd(9,6) then returns 3 with iters=2.
- Back-to-back jobs:
  - Hold in_valid with the pairs (35,10), then (17,5) → results 5 then 1, in order.
  - Each new acceptance occurs only after the previous out handshake.
